// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops plus a multi-cycle shift-add MUL,
// with a one-entry writeback output slot toward the register file.
module alu_exec_unit #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_code,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [ADDR_W-1:0] result_addr,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StMfin} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [ADDR_W-1:0]   mul_addr_q, mul_addr_d;

  logic                out_valid_q;
  logic [WIDTH-1:0]    result_q;
  logic [ADDR_W-1:0]   result_addr_q;
  logic                flag_zero_q;
  logic                flag_carry_q;

  logic                slot_free;
  logic                accept;
  logic                slot_load;
  logic [WIDTH-1:0]    load_res;
  logic                load_carry;
  logic [ADDR_W-1:0]   load_addr;

  logic [WIDTH-1:0]    alu_res;
  logic                alu_carry;
  logic [WIDTH:0]      sum;
  logic [2:0]          shamt;
  logic [2*WIDTH-1:0]  partial;

  // The slot can take a new result if empty or being drained this edge.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = reset && (state_q == StIdle) && slot_free;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != StIdle);

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign result_addr = result_addr_q;
  assign flag_zero   = flag_zero_q;
  assign flag_carry  = flag_carry_q;

  // Single-cycle ALU on the presented operands.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum       = '0;
    shamt     = operand_b[2:0];
    case (op_code)
      OpAdd: begin
        sum       = {1'b0, operand_a} + {1'b0, operand_b};
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OpSub: begin
        alu_res   = operand_a - operand_b;
        alu_carry = (operand_a < operand_b);
      end
      OpAnd:   alu_res = operand_a & operand_b;
      OpOr:    alu_res = operand_a | operand_b;
      OpXor:   alu_res = operand_a ^ operand_b;
      OpShl:   alu_res = operand_a << shamt;
      OpShr:   alu_res = operand_a >> shamt;
      default: alu_res = '0;
    endcase
  end

  // Multiplicand aligned to the current multiplier bit position.
  assign partial = {{WIDTH{1'b0}}, mcand_q} << cnt_q;

  // Next-state logic for the sequencer and output-slot load requests.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    mul_addr_d = mul_addr_q;
    slot_load  = 1'b0;
    load_res   = '0;
    load_carry = 1'b0;
    load_addr  = '0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (op_code == OpMul) begin
            acc_d      = '0;
            mcand_d    = operand_a;
            mplier_d   = operand_b;
            mul_addr_d = dest_addr;
            cnt_d      = '0;
            state_d    = StMul;
          end else begin
            slot_load  = 1'b1;
            load_res   = alu_res;
            load_carry = alu_carry;
            load_addr  = dest_addr;
          end
        end
      end
      StMul: begin
        if (mplier_q[cnt_q]) begin
          acc_d = acc_q + partial;
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StMfin;
        end
      end
      StMfin: begin
        if (slot_free) begin
          slot_load  = 1'b1;
          load_res   = acc_q[WIDTH-1:0];
          load_carry = |acc_q[2*WIDTH-1:WIDTH];
          load_addr  = mul_addr_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and MUL datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      mul_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      mul_addr_q <= mul_addr_d;
    end
  end

  // Output slot: a load wins over a drain at the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      result_q      <= '0;
      result_addr_q <= '0;
      flag_zero_q   <= 1'b0;
      flag_carry_q  <= 1'b0;
    end else if (slot_load) begin
      out_valid_q   <= 1'b1;
      result_q      <= load_res;
      result_addr_q <= load_addr;
      flag_zero_q   <= (load_res == '0);
      flag_carry_q  <= load_carry;
    end else if (out_valid_q && out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute stage directly downstream of the command decoder/controller. Accepts one decoded operation per handshake (3-bit op code, two operands already read from the 8-entry register file, destination address), computes the result, and presents it with flags on a writeback handshake toward the register file. Single-cycle ops complete in one cycle. MUL is a multi-cycle shift-add sequence that back-pressures the controller while it runs.

## Interface
- WIDTH, 8: operand/result width; also the MUL iteration count.
- ADDR_W, 3: register address width (8 registers).

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- in_valid  in  1  controller presents an operation.
- in_ready  out  1  block accepts the operation this cycle.
- op_code  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- operand_a  in  WIDTH  first operand.
- operand_b  in  WIDTH  second operand.
- dest_addr  in  ADDR_W  writeback register address.
- out_valid  out  1  result/flags/result_addr valid.
- out_ready  in  1  register file consumes the result this cycle.
- result  out  WIDTH  computed value.
- result_addr  out  ADDR_W  copy of dest_addr of the op that produced result.
- flag_zero  out  1  result == 0.
- flag_carry  out  1  carry/borrow/overflow, per op.
- busy  out  1  high while a MUL is in progress (MUL or MFIN state).

## Operation
- Accept: in_valid && in_ready at a rising edge. Op code, operands and dest_addr are captured at that edge. Inputs are don't-care at all other times.
- in_ready = reset high && state==IDLE && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- Output slot: a single register. out_valid stays set, and result/result_addr/flags stay stable, until the edge where out_valid && out_ready. On that edge out_valid clears unless a new result loads at the same edge.
- States:
  - IDLE: on accepting a non-MUL op, load the output slot and stay in IDLE. On accepting a MUL op, clear the accumulator, latch the operands, set count=0 and go to MUL.
  - MUL: one shift-add iteration per cycle: if multiplier bit[count] is set, add the multiplicand shifted by count into a 2*WIDTH accumulator. count increments each cycle. After the iteration with count==WIDTH-1, go to MFIN.
  - MFIN: when !out_valid || out_ready, load the output slot and go to IDLE. Otherwise hold.
- Arithmetic (WIDTH bits, unsigned):
  - ADD: result = a+b mod 2^WIDTH; carry = bit WIDTH of the sum.
  - SUB: result = a-b mod 2^WIDTH; carry = 1 iff a<b (borrow).
  - AND, OR, XOR: bitwise; carry = 0.
  - SHL: a << b[2:0]; carry = 0.
  - SHR: logical a >> b[2:0]; carry = 0.
  - MUL: result = low WIDTH bits of a*b; carry = 1 iff the high WIDTH bits are nonzero.
- flag_zero is computed from the loaded result for every op.

## Timing
- Reset (reset==0 at an edge): state=IDLE, count=0, accumulator=0, out_valid=0, result=0, result_addr=0, flag_zero=0, flag_carry=0, busy=0. in_ready is 0 while reset is low.
- Reset mid-MUL aborts the operation; nothing is written back. Reset with out_valid high drops the pending result.
- Non-MUL latency: accepted in cycle N, out_valid high in cycle N+1.
- MUL latency: accepted in cycle N, MUL state in cycles N+1..N+WIDTH, MFIN in N+WIDTH+1, out_valid in N+WIDTH+2 (N+10 for WIDTH=8) if the slot is free. Each stalled cycle in MFIN adds one cycle.
- Back-to-back non-MUL ops with out_ready held high: one op per cycle, full throughput.
- Simultaneous drain and load at the same edge: the new result replaces the old and out_valid stays 1. No bubble and no duplicate.
- Shift amount b[2:0]=0 returns a unchanged.

## Test plan
- ADD a=0xF0, b=0x20, dest=3 -> next cycle out_valid=1, result=0x10, carry=1, zero=0, result_addr=3.
- SUB a=0x05, b=0x05 -> result=0x00, zero=1, carry=0. Then SUB a=0x03, b=0x05 -> result=0xFE, carry=1.
- MUL a=0x0C, b=0x0B, out_ready=1 -> in_ready low and busy high for cycles N+1..N+9; out_valid in N+10 with result=0x84, carry=0. Then MUL 0x20*0x10 -> result=0x00, carry=1, zero=1.
- Back-pressure: out_ready=0 with an ADD pending -> in_ready=0 and outputs stable for 5 cycles. Raise out_ready with in_valid high -> drain and accept at the same edge; the next result appears the following cycle.
- Stream XOR, OR, AND, SHL(a=0x81, b=1 -> 0x02), SHR(a=0x81, b=7 -> 0x01) with out_ready=1 -> one result per cycle, in order, with correct result_addr.
- Assert reset low during MUL cycle 4 -> next cycle state IDLE, out_valid=0, busy=0, all outputs 0. After reset is released, in_ready=1 and a new ADD completes normally.
